adsr_envelope_gated: RTL and testbench

Gate-triggered, parametrised ADSR envelope generator with a built-in amplitude modulator. It generalises the free-running envelope to a configurable WIDTH and adds an external `gate`, per-phase rate prescaling, retrigger from the current level, and live sustain tracking. It sits between the waveform generators and the output DAC path: it takes one waveform sample stream and emits the enveloped sample together with envelope status.

---
 rtl/adsr_envelope_gated_pkg.sv | 14 +
 rtl/adsr_envelope_gated_rate_tick.sv | 28 ++
 rtl/adsr_envelope_gated.sv | 106 ++++++++++
 tb/tb_adsr_envelope_gated.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/adsr_envelope_gated_pkg.sv
// Shared phase encoding for the gated ADSR envelope generator.
package adsr_pkg;

  localparam int unsigned PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } phase_e;

endpackage

// File: rtl/adsr_envelope_gated_rate_tick.sv
// Step-rate prescaler: emits one tick every rate+1 enabled cycles.
module adsr_rate_tick #(
  parameter int unsigned RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [RATE_W-1:0] count;

  assign tick = enable && (count == rate);

  // A rate lowered below the current count lets the counter wrap through zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + RATE_W'(1);
    end
  end

endmodule

// File: rtl/adsr_envelope_gated.sv
// Gate-triggered ADSR envelope with retrigger-from-level and a registered
// amplitude modulator on the incoming waveform.
module adsr_envelope_gated
  import adsr_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned RATE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               gate,
  input  logic [RATE_W-1:0]  attack_rate,
  input  logic [RATE_W-1:0]  decay_rate,
  input  logic [WIDTH-1:0]   sustain_level,
  input  logic [RATE_W-1:0]  release_rate,
  input  logic [WIDTH-1:0]   wave_in,
  output logic [WIDTH-1:0]   wave_out,
  output logic [WIDTH-1:0]   amplitude,
  output logic [PHASE_W-1:0] phase,
  output logic               active
);

  localparam logic [WIDTH-1:0] MAX = '1;

  phase_e              state;
  phase_e              state_next;
  logic [WIDTH-1:0]    amp_next;
  logic                gate_q;
  logic                rise;
  logic                tick;
  logic                counting;
  logic                clear;
  logic [RATE_W-1:0]   rate;
  logic [2*WIDTH-1:0]  product;

  assign rise    = gate & ~gate_q;
  assign phase   = state;
  assign active  = (state != IDLE);
  assign product = (2*WIDTH)'(wave_in) * (2*WIDTH)'(amplitude);

  always_comb begin
    rate     = '0;
    counting = 1'b0;
    case (state)
      ATTACK:  begin rate = attack_rate;  counting = 1'b1; end
      DECAY:   begin rate = decay_rate;   counting = 1'b1; end
      RELEASE: begin rate = release_rate; counting = 1'b1; end
      default: ;
    endcase
  end

  // A retrigger while already attacking restarts the step timer as well.
  assign clear = rise || (state_next != state);

  adsr_rate_tick #(.RATE_W(RATE_W)) u_rate_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .enable (counting),
    .rate   (rate),
    .tick   (tick)
  );

  always_comb begin
    state_next = state;
    amp_next   = amplitude;
    if (rise) begin
      state_next = ATTACK;
    end else if (!gate && (state inside {ATTACK, DECAY, SUSTAIN})) begin
      state_next = RELEASE;
    end else begin
      case (state)
        IDLE: amp_next = '0;
        ATTACK: if (tick) begin
          if (amplitude != MAX) amp_next = amplitude + WIDTH'(1);
          if (amp_next == MAX) state_next = DECAY;
        end
        DECAY: if (tick) begin
          if (amplitude > sustain_level) amp_next = amplitude - WIDTH'(1);
          if (amp_next <= sustain_level) state_next = SUSTAIN;
        end
        SUSTAIN: amp_next = sustain_level;
        RELEASE: if (tick) begin
          if (amplitude != '0) amp_next = amplitude - WIDTH'(1);
          if (amp_next == '0) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      amplitude <= '0;
      gate_q    <= 1'b0;
      wave_out  <= '0;
    end else begin
      state     <= state_next;
      amplitude <= amp_next;
      gate_q    <= gate;
      wave_out  <= product[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_adsr_envelope_gated.sv
// Directed bench for adsr_envelope_gated: per-cycle envelope model plus literal checkpoints.
module tb_adsr_envelope_gated;

  localparam int W  = 8;
  localparam int RW = 8;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gate = 1'b0;
  logic [RW-1:0] attack_rate = '0;
  logic [RW-1:0] decay_rate = '0;
  logic [W-1:0]  sustain_level = 8'd128;
  logic [RW-1:0] release_rate = '0;
  logic [W-1:0]  wave_in = 8'd200;
  logic [W-1:0]  wave_out;
  logic [W-1:0]  amplitude;
  logic [2:0]    phase;
  logic          active;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adsr_envelope_gated #(.WIDTH(W), .RATE_W(RW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .wave_in       (wave_in),
    .wave_out      (wave_out),
    .amplitude     (amplitude),
    .phase         (phase),
    .active        (active)
  );

  // Envelope state in plain integers: phase number, level, cycles since last step.
  typedef struct {
    int ph;
    int amp;
    int cnt;
    int gq;
    int wout;
  } env_t;

  env_t m = '{0, 0, 0, 0, 0};

  function automatic env_t model_step(env_t s);
    env_t n;
    int   r;
    bit   step;
    n      = s;
    n.gq   = int'(gate);
    n.wout = (int'(wave_in) * s.amp) / (1 << W);
    if (gate && s.gq == 0) begin
      n.ph  = 1;
      n.cnt = 0;
    end else if (!gate && s.ph >= 1 && s.ph <= 3) begin
      n.ph  = 4;
      n.cnt = 0;
    end else if (s.ph == 0) begin
      n.amp = 0;
    end else if (s.ph == 3) begin
      n.amp = int'(sustain_level);
    end else begin
      r = (s.ph == 1) ? int'(attack_rate) : (s.ph == 2) ? int'(decay_rate) : int'(release_rate);
      step = (s.cnt == r);
      n.cnt = step ? 0 : (s.cnt + 1) % (1 << RW);
      if (step) begin
        if (s.ph == 1) begin
          n.amp = (s.amp < MAXV) ? s.amp + 1 : s.amp;
          if (n.amp == MAXV) n.ph = 2;
        end else if (s.ph == 2) begin
          n.amp = (s.amp > int'(sustain_level)) ? s.amp - 1 : s.amp;
          if (n.amp <= int'(sustain_level)) n.ph = 3;
        end else begin
          n.amp = (s.amp > 0) ? s.amp - 1 : 0;
          if (n.amp == 0) n.ph = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{0, 0, 0, 0, 0};
    else        m <= model_step(m);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_amplitude", int'(amplitude), m.amp);
    chk("model_phase",     int'(phase),     m.ph);
    chk("model_active",    int'(active),    (m.ph != 0) ? 1 : 0);
    chk("model_wave_out",  int'(wave_out),  m.wout);
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_lit(input string name, input int amp_exp, input int ph_exp);
    chk({name, "_amp"},   int'(amplitude), amp_exp);
    chk({name, "_phase"}, int'(phase),     ph_exp);
  endtask

  initial begin
    #2;
    chk_lit("reset", 0, 0);
    chk("reset_active", int'(active), 0);
    chk("reset_wave_out", int'(wave_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(2);
    chk_lit("idle_no_gate", 0, 0);

    // Full attack/decay into sustain with unit rates
    gate = 1'b1;
    wait_n(1);   chk_lit("attack_entry", 0, 1);
    wait_n(1);   chk_lit("attack_first_step", 1, 1);
    wait_n(254); chk_lit("attack_peak", 255, 2);
    wait_n(127); chk_lit("decay_to_sustain", 128, 3);
    wait_n(1);   chk("mod_200x128", int'(wave_out), 100);
    sustain_level = 8'd64;
    wait_n(1);   chk_lit("sustain_track", 64, 3);
    wait_n(1);   chk("mod_200x64", int'(wave_out), 50);
    sustain_level = 8'd128;
    wait_n(2);

    // Release at half rate
    release_rate = 8'd1;
    gate = 1'b0;
    wait_n(1);   chk_lit("release_entry", 128, 4);
    wait_n(2);   chk_lit("release_first_step", 127, 4);
    wait_n(253); chk_lit("release_last_nonzero", 1, 4);
    wait_n(1);   chk_lit("release_done", 0, 0);
    chk("release_done_active", int'(active), 0);

    // Retrigger from the middle of a release
    release_rate = 8'd0;
    gate = 1'b1;
    wait_n(383); chk_lit("second_sustain", 128, 3);
    gate = 1'b0;
    wait_n(29);  chk_lit("release_at_100", 100, 4);
    gate = 1'b1;
    wait_n(1);   chk_lit("retrigger_keeps_level", 100, 1);
    wait_n(154); chk_lit("retrigger_254", 254, 1);
    wait_n(1);   chk_lit("retrigger_peak", 255, 2);

    // Slow attack, gate dropped mid-attack
    gate = 1'b0;
    wait_n(300); chk_lit("back_to_idle", 0, 0);
    attack_rate = 8'd3;
    gate = 1'b1;
    wait_n(1);   chk_lit("slow_attack_entry", 0, 1);
    wait_n(3);   chk_lit("slow_attack_wait", 0, 1);
    wait_n(1);   chk_lit("slow_attack_step1", 1, 1);
    wait_n(36);  chk_lit("slow_attack_10", 10, 1);
    gate = 1'b0;
    wait_n(1);   chk_lit("gate_low_mid_attack", 10, 4);

    // Asynchronous reset mid-decay, gate held high across release
    wait_n(20);
    attack_rate = 8'd0;
    decay_rate = 8'd3;
    sustain_level = 8'd0;
    gate = 1'b1;
    wait_n(301); chk_lit("slow_decay", 244, 2);
    #2 rst_n = 1'b0;
    #1;
    chk_lit("async_reset", 0, 0);
    chk("async_reset_active", int'(active), 0);
    chk("async_reset_wave_out", int'(wave_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(1);   chk_lit("gate_through_reset", 0, 1);
    chk("gate_through_reset_active", int'(active), 1);
    wait_n(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
